// File: rtl/cpu_pkg.sv
// Shared types and defaults for the CPU pipeline stages.
package cpu_pkg;

  typedef enum logic [1:0] {
    MEM_NONE = 2'b00,
    MEM_LDR  = 2'b01,
    MEM_STR  = 2'b10
  } mem_op_t;

  typedef enum logic {
    MU_IDLE = 1'b0,
    MU_WAIT = 1'b1
  } mu_state_t;

  localparam int MU_TIMEOUT_CYC = 16;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter for the memory unit; hit flags the last permitted WAIT cycle.
module mem_timeout_ctr #(
  parameter int TIMEOUT_CYC = cpu_pkg::MU_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [7:0] TERM = 8'(TIMEOUT_CYC - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = 8'd0;
    else if (en) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end

  assign hit = (cnt_q == TERM);

endmodule

// File: rtl/memory_unit.sv
// Memory pipeline stage: issues LDR/STR over a ready handshake, returns load data
// to the regfile load port and stalls upstream while an access is outstanding.
//
// state   | meaning
// MU_IDLE | accepting ops; NONE passes through, LDR/STR launch a request
// MU_WAIT | request outstanding; bus outputs frozen, upstream stalled
module memory_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int TIMEOUT_CYC = MU_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [1:0]        in_op,
  input  logic [31:0]       in_addr,
  input  logic [31:0]       in_str_data,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rn,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rdy,
  output logic              w_en_ldr,
  output logic [3:0]        w_addr_ldr,
  output logic [31:0]       w_data_ldr,
  output logic [3:0]        rd_memory_unit,
  output logic [3:0]        rn_memory_unit,
  output logic              mem_err
);

  mu_state_t         state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              wen_q, wen_d;
  logic [3:0]        waddr_q, waddr_d;
  logic [31:0]       wdat_q, wdat_d;
  logic [3:0]        rd_q, rd_d;
  logic [3:0]        rn_q, rn_d;
  logic              err_q, err_d;
  logic              cnt_clr, cnt_en, cnt_hit;
  logic              op_ldr, op_str;

  assign op_ldr = (in_op == MEM_LDR);
  assign op_str = (in_op == MEM_STR);

  mem_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .hit (cnt_hit)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdat_d  = wdat_q;
    rd_d    = rd_q;
    rn_d    = rn_q;
    err_d   = err_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      MU_IDLE: begin
        if (in_valid) begin
          rd_d = in_rd;
          rn_d = in_rn;
          if (op_ldr || op_str) begin
            addr_d  = in_addr[ADDR_W-1:0];
            if (op_str) wdata_d = in_str_data;
            waddr_d = in_rd;
            we_d    = op_str;
            req_d   = 1'b1;
            cnt_clr = 1'b1;
            state_d = MU_WAIT;
          end
        end
      end
      MU_WAIT: begin
        // Completion takes priority over a timeout on the same edge.
        if (mem_rdy) begin
          req_d   = 1'b0;
          state_d = MU_IDLE;
          if (!we_q) begin
            wdat_d = mem_rdata;
            wen_d  = 1'b1;
          end
        end else if (cnt_hit) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = MU_IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_d = MU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MU_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdat_q  <= '0;
      rd_q    <= '0;
      rn_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdat_q  <= wdat_d;
      rd_q    <= rd_d;
      rn_q    <= rn_d;
      err_q   <= err_d;
    end
  end

  assign stall          = (state_q == MU_WAIT);
  assign mem_req        = req_q;
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign w_en_ldr       = wen_q;
  assign w_addr_ldr     = waddr_q;
  assign w_data_ldr     = wdat_q;
  assign rd_memory_unit = rd_q;
  assign rn_memory_unit = rn_q;
  assign mem_err        = err_q;

endmodule

// File: tb/tb_memory_unit.sv
// Directed self-checking bench for memory_unit.
module tb_memory_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  in_op;
  logic [31:0] in_addr, in_str_data;
  logic [3:0]  in_rd, in_rn;
  logic        stall, mem_req, mem_we;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_rdy;
  logic        w_en_ldr;
  logic [3:0]  w_addr_ldr;
  logic [31:0] w_data_ldr;
  logic [3:0]  rd_memory_unit, rn_memory_unit;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_unit #(.ADDR_W(11), .TIMEOUT_CYC(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_op          (in_op),
    .in_addr        (in_addr),
    .in_str_data    (in_str_data),
    .in_rd          (in_rd),
    .in_rn          (in_rn),
    .stall          (stall),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_rdy        (mem_rdy),
    .w_en_ldr       (w_en_ldr),
    .w_addr_ldr     (w_addr_ldr),
    .w_data_ldr     (w_data_ldr),
    .rd_memory_unit (rd_memory_unit),
    .rn_memory_unit (rn_memory_unit),
    .mem_err        (mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = MEM_NONE; in_addr = '0; in_str_data = '0;
    in_rd = '0; in_rn = '0; mem_rdata = '0; mem_rdy = 1'b0;
    tick(); tick();
    chk("rst_stall", 32'(stall), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_err", 32'(mem_err), 0);
    chk("rst_wen", 32'(w_en_ldr), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_rd", 32'(rd_memory_unit), 0);

    // Reset while a load is outstanding
    rst = 1'b0;
    in_valid = 1'b1; in_op = MEM_LDR; in_addr = 32'h24; in_rd = 4'd3; in_rn = 4'd2;
    tick();
    in_valid = 1'b0;
    chk("rw_req", 32'(mem_req), 1);
    chk("rw_stall", 32'(stall), 1);
    chk("rw_addr", 32'(mem_addr), 32'h24);
    rst = 1'b1;
    tick();
    chk("rw_req_drop", 32'(mem_req), 0);
    chk("rw_stall_drop", 32'(stall), 0);
    chk("rw_wen", 32'(w_en_ldr), 0);
    chk("rw_addr0", 32'(mem_addr), 0);
    chk("rw_rd0", 32'(rd_memory_unit), 0);
    chk("rw_waddr0", 32'(w_addr_ldr), 0);
    rst = 1'b0;
    tick();
    chk("rw_wen_after", 32'(w_en_ldr), 0);
    chk("rw_req_after", 32'(mem_req), 0);

    // Zero-wait load
    in_valid = 1'b1; in_op = MEM_LDR; in_addr = 32'h24; in_rd = 4'd3; in_rn = 4'd1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    in_valid = 1'b0; mem_rdy = 1'b1;
    chk("ld_req", 32'(mem_req), 1);
    chk("ld_we", 32'(mem_we), 0);
    chk("ld_addr", 32'(mem_addr), 32'h024);
    chk("ld_wen_early", 32'(w_en_ldr), 0);
    chk("ld_stall", 32'(stall), 1);
    tick();
    mem_rdy = 1'b0;
    chk("ld_wen", 32'(w_en_ldr), 1);
    chk("ld_waddr", 32'(w_addr_ldr), 3);
    chk("ld_wdata", w_data_ldr, 32'hDEAD_BEEF);
    chk("ld_req_drop", 32'(mem_req), 0);
    chk("ld_stall_drop", 32'(stall), 0);
    chk("ld_rd", 32'(rd_memory_unit), 3);
    chk("ld_rn", 32'(rn_memory_unit), 1);
    tick();
    chk("ld_wen_once", 32'(w_en_ldr), 0);
    chk("ld_wdata_hold", w_data_ldr, 32'hDEAD_BEEF);

    // Store with three wait cycles; in_valid during WAIT must be ignored
    in_valid = 1'b1; in_op = MEM_STR; in_addr = 32'h10; in_str_data = 32'h1234_5678;
    in_rd = 4'd7; in_rn = 4'd9;
    tick();
    in_op = MEM_NONE; in_rd = 4'd14; in_rn = 4'd13;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin mem_rdy = 1'b1; in_valid = 1'b0; end
      chk("st_req", 32'(mem_req), 1);
      chk("st_we", 32'(mem_we), 1);
      chk("st_addr", 32'(mem_addr), 32'h10);
      chk("st_wdata", mem_wdata, 32'h1234_5678);
      chk("st_stall", 32'(stall), 1);
      chk("st_wen", 32'(w_en_ldr), 0);
      chk("st_rd_hold", 32'(rd_memory_unit), 7);
      tick();
    end
    mem_rdy = 1'b0;
    chk("st_req_drop", 32'(mem_req), 0);
    chk("st_wen_none", 32'(w_en_ldr), 0);
    chk("st_stall_drop", 32'(stall), 0);
    chk("st_rn_hold", 32'(rn_memory_unit), 9);

    // Timeout after 16 WAIT cycles
    in_valid = 1'b1; in_op = MEM_LDR; in_addr = 32'h30; in_rd = 4'd5; in_rn = 4'd0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("to_req_hold", 32'(mem_req), 1);
      chk("to_err_low", 32'(mem_err), 0);
      tick();
    end
    chk("to_req_drop", 32'(mem_req), 0);
    chk("to_err", 32'(mem_err), 1);
    chk("to_wen", 32'(w_en_ldr), 0);
    chk("to_stall", 32'(stall), 0);

    // Successful load afterwards: error stays sticky; address truncates to 11 bits
    in_valid = 1'b1; in_op = MEM_LDR; in_addr = 32'hFFFF_F844; in_rd = 4'd6;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    in_valid = 1'b0; mem_rdy = 1'b1;
    chk("st2_addr_trunc", 32'(mem_addr), 32'h044);
    tick();
    mem_rdy = 1'b0;
    chk("ld2_wen", 32'(w_en_ldr), 1);
    chk("ld2_wdata", w_data_ldr, 32'hCAFE_F00D);
    chk("ld2_waddr", 32'(w_addr_ldr), 6);
    chk("ld2_err_sticky", 32'(mem_err), 1);
    tick();
    chk("ld2_err_sticky2", 32'(mem_err), 1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("err_cleared", 32'(mem_err), 0);

    // NONE passthrough stream, last one uses the reserved encoding
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_op = (i == 3) ? 2'b11 : MEM_NONE;
      in_addr = 32'h100 + 32'(i); in_rd = 4'(i + 1); in_rn = 4'(i + 5);
      tick();
      chk("pt_rd", 32'(rd_memory_unit), 32'(i + 1));
      chk("pt_rn", 32'(rn_memory_unit), 32'(i + 5));
      chk("pt_stall", 32'(stall), 0);
      chk("pt_req", 32'(mem_req), 0);
    end
    in_valid = 1'b0;

    // Completion on the timeout edge wins; rd=15 load passes through unchanged
    in_valid = 1'b1; in_op = MEM_LDR; in_addr = 32'h8; in_rd = 4'd15; in_rn = 4'd4;
    mem_rdata = 32'h0000_1000;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("te_req_before", 32'(mem_req), 1);
    mem_rdy = 1'b1;
    tick();
    mem_rdy = 1'b0;
    chk("te_wen", 32'(w_en_ldr), 1);
    chk("te_waddr", 32'(w_addr_ldr), 15);
    chk("te_wdata", w_data_ldr, 32'h0000_1000);
    chk("te_err", 32'(mem_err), 0);
    chk("te_req", 32'(mem_req), 0);
    tick();
    chk("te_wen_once", 32'(w_en_ldr), 0);
    chk("te_err_after", 32'(mem_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_unit.md
Name: memory_unit

Overview:
- Pipeline stage directly downstream of the execute datapath.
- Consumes the execute result (address or ALU value), the store data and the destination/base register numbers.
- Performs LDR/STR accesses to data memory over a ready-handshake bus.
- Returns load results to the regfile's load write port (w_en_ldr / w_addr_ldr / w_data_ldr) and supplies rd_memory_unit / rn_memory_unit for the datapath's write-address mux. Stalls upstream while an access is outstanding.

Parameters:
- ADDR_W, 11, data-memory word-address width; mem_addr = in_addr[ADDR_W-1:0].
- TIMEOUT_CYC, 16, maximum WAIT cycles before an access is abandoned. Legal range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  execute result valid this cycle.
- in_op  in  2  2'b00 NONE (ALU passthrough), 2'b01 LDR, 2'b10 STR, 2'b11 reserved, treated as NONE.
- in_addr  in  32  execute datapath output (effective address).
- in_str_data  in  32  store data from the regfile str port.
- in_rd  in  4  destination/source register number.
- in_rn  in  4  base register number.
- stall  out  1  upstream must hold its outputs; combinational, 1 whenever state==WAIT.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  load data, valid when mem_rdy=1.
- mem_rdy  in  1  memory completes the access this cycle.
- w_en_ldr  out  1  one-cycle load writeback strobe.
- w_addr_ldr  out  4  load destination register.
- w_data_ldr  out  32  load data.
- rd_memory_unit  out  4  registered in_rd of the last accepted op.
- rn_memory_unit  out  4  registered in_rn of the last accepted op.
- mem_err  out  1  sticky timeout flag.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high.
- While rst=1 at a clock edge:
  - state -> IDLE.
  - All outputs and registers -> 0.
  - mem_err cleared.
  - Any outstanding request is dropped; mem_req=0 from the following cycle.
  - A pending w_en_ldr pulse is cancelled.
- States: IDLE, WAIT.
- IDLE:
  - Input is accepted at an edge where in_valid=1.
  - On accept, rd_memory_unit <= in_rd and rn_memory_unit <= in_rn for every op.
  - NONE: no memory activity; remain IDLE.
  - LDR or STR:
    - Latch mem_addr <= in_addr[ADDR_W-1:0].
    - Latch mem_wdata <= in_str_data (STR only; unchanged for LDR).
    - Latch w_addr_ldr <= in_rd.
    - Set mem_we = (op==STR) and mem_req <= 1, wait counter <= 0, go to WAIT.
  - mem_rdy seen in IDLE is ignored.
- WAIT:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable. in_valid is ignored, which is why stall=1.
  - Each edge with mem_rdy=0 increments the wait counter.
  - Edge with mem_rdy=1:
    - mem_req <= 0, go to IDLE.
    - If LDR: w_data_ldr <= mem_rdata and w_en_ldr <= 1 for exactly one cycle.
  - Edge with mem_rdy=0 and counter == TIMEOUT_CYC-1:
    - mem_req <= 0, mem_err <= 1 (sticky until rst), go to IDLE.
    - No writeback.
  - mem_rdy=1 on the timeout edge: completion wins, no error.
- Latency:
  - Accept at edge T gives mem_req=1 in cycle T..T+1.
  - Earliest mem_rdy is sampled at edge T+1.
  - LDR w_en_ldr is high in cycle T+1..T+2.
  - Back-to-back: a new op may be accepted at the same edge on which w_en_ldr is asserted (that edge returns to IDLE; acceptance happens the next edge). Throughput is one memory op per 2 cycles minimum. NONE ops are accepted every cycle.
- w_en_ldr is 0 in every cycle other than the single writeback cycle. w_addr_ldr and w_data_ldr hold their last values.
- LDR with rd=15 is allowed; the pulse is produced unchanged and the regfile handles PC load.
- stall is purely combinational from state. It must not depend on in_valid, to avoid loops with upstream.

Decomposition:
- Shared package (cpu_pkg):
  - mem_op_t enum {MEM_NONE=2'b00, MEM_LDR=2'b01, MEM_STR=2'b10}.
  - mu_state_t enum {MU_IDLE, MU_WAIT}.
  - Default constant MU_TIMEOUT_CYC=16.
- One natural sub-module: mem_timeout_ctr.
  - Ports: clk, rst, clr, en, hit.
  - 8-bit wait counter with terminal compare against TIMEOUT_CYC-1.
- FSM and output registers stay in memory_unit.

Test Plan:
- Reset mid-WAIT: LDR to addr 0x24 accepted, rst at T+1 -> mem_req=0 at T+2, state IDLE, w_en_ldr never pulses, all outputs 0.
- LDR, zero-wait: in_op=LDR, in_addr=0x0000_0024, in_rd=3, mem_rdata=0xDEAD_BEEF with mem_rdy at T+1 -> mem_addr=0x024, mem_we=0, w_en_ldr=1 in one cycle only, w_addr_ldr=3, w_data_ldr=0xDEADBEEF.
- STR with 3 wait cycles: in_op=STR, in_addr=0x10, in_str_data=0x1234_5678 -> mem_we=1, mem_addr/wdata stable for 4 cycles, stall=1 throughout WAIT, in_valid pulses during WAIT ignored, no w_en_ldr.
- Timeout: LDR with mem_rdy held 0 -> mem_req drops after 16 WAIT cycles, mem_err=1 and stays 1 across later successful LDRs until rst.
- Passthrough stream: 4 consecutive NONE ops with rd=1..4, rn=5..8 -> rd_memory_unit/rn_memory_unit update each cycle, stall=0, mem_req=0.
- Completion on timeout edge: mem_rdy=1 exactly at wait count 15 with LDR -> w_en_ldr pulses, mem_err stays 0.
